// File: rtl/buff_uart_pkg.sv
// rtl/buff_uart_pkg.sv - shared UART types and bit-timing helper
package buff_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff #(
    parameter logic reset_val = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= reset_val;
            q    <= reset_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/buff_uart_rx.sv
// rtl/buff_uart_rx.sv - UART receiver with one-deep output buffer
module buff_uart_rx
    import buff_uart_pkg::*;
#(
    parameter int width      = 8,
    parameter int baud_rate  = 9600,
    parameter int clock_freq = 460800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [width-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(clock_freq, baud_rate);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (width > 1) ? $clog2(width) : 1;

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_timing
            $error("buff_uart_rx: clock_freq/baud_rate must be at least 4");
        end
    endgenerate

    rx_state_t        state, state_next;
    logic             rx_s;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [width-1:0] shreg;
    logic             start_edge;
    logic             start_sample;
    logic             data_sample;
    logic             stop_sample;

    sync_2ff #(.reset_val(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        start_edge   = 1'b0;
        start_sample = 1'b0;
        data_sample  = 1'b0;
        stop_sample  = 1'b0;
        case (state)
            IDLE: begin
                // Edge-only trigger keeps a held-low break from restarting frames.
                if (rx_prev && !rx_s) begin
                    start_edge = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (cnt == CNT_W'(HALF_BIT - 1)) begin
                    start_sample = 1'b1;
                    state_next   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    data_sample = 1'b1;
                    if (bit_idx == IDX_W'(width - 1)) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    stop_sample = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rx_prev <= rx_s;
            if (state == IDLE || start_sample || data_sample || stop_sample) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (start_edge) begin
                bit_idx <= '0;
            end else if (data_sample) begin
                bit_idx <= bit_idx + IDX_W'(1);
                shreg   <= {rx_s, shreg[width-1:1]};
            end
        end
    end

    // A good stop bit loads only when the buffer is free or being drained this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (stop_sample && rx_s && (!valid || ready)) begin
                data_out <= shreg;
                valid    <= 1'b1;
            end else begin
                if (valid && ready) begin
                    valid <= 1'b0;
                end
                if (stop_sample) begin
                    if (rx_s) begin
                        overrun <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
